// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Multiplexed seven-segment driver with hex / double-dabble decimal
//            conversion, leading-zero blanking, decimal points and overflow.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int DATA_W   = 16,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              load,
    input  logic              mode,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp,
    output logic [7:0]        dis,
    output logic [DIGITS-1:0] cs,
    output logic              busy
);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_PRE_W = $clog2(SCAN_DIV);
    localparam int c_IDX_W = $clog2(DIGITS);
    localparam int c_CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEX   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [DATA_W-1:0]      r_val;
    logic                   r_mode;
    logic                   r_blank;
    logic [DIGITS-1:0]      r_dpc;
    logic [c_BCD_W-1:0]     r_bcd;
    logic                   r_ovf;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [DIGITS-1:0][7:0] r_disp;
    logic [DIGITS-1:0][7:0] w_new_disp;
    logic [c_BCD_W-1:0]     w_bcd_adj;
    logic [c_BCD_W-1:0]     w_hex;
    logic [c_PRE_W-1:0]     r_pre;
    logic [c_IDX_W-1:0]     r_idx;
    logic [c_IDX_W-1:0]     w_idx_nxt;
    logic                   w_wrap;

    function automatic logic [6:0] f_glyph(input logic [3:0] v);
        case (v)
            4'h0:    f_glyph = 7'h40;
            4'h1:    f_glyph = 7'h79;
            4'h2:    f_glyph = 7'h24;
            4'h3:    f_glyph = 7'h30;
            4'h4:    f_glyph = 7'h19;
            4'h5:    f_glyph = 7'h12;
            4'h6:    f_glyph = 7'h02;
            4'h7:    f_glyph = 7'h78;
            4'h8:    f_glyph = 7'h00;
            4'h9:    f_glyph = 7'h10;
            4'hA:    f_glyph = 7'h08;
            4'hB:    f_glyph = 7'h03;
            4'hC:    f_glyph = 7'h46;
            4'hD:    f_glyph = 7'h21;
            4'hE:    f_glyph = 7'h06;
            default: f_glyph = 7'h0E;
        endcase
    endfunction

    // Hex nibbles above DATA_W read as zero; nibbles above DIGITS are dropped.
    generate
        if (DATA_W >= c_BCD_W) begin : g_hex_trunc
            assign w_hex = r_val[c_BCD_W-1:0];
        end else begin : g_hex_pad
            assign w_hex = {{(c_BCD_W-DATA_W){1'b0}}, r_val};
        end
    endgenerate

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Walk from the top digit down so v_nz means "this digit or one above is nonzero".
    always_comb begin
        logic [3:0] v_dig;
        logic       v_nz;
        v_dig      = 4'd0;
        v_nz       = 1'b0;
        w_new_disp = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            v_dig = r_mode ? r_bcd[4*i +: 4] : w_hex[4*i +: 4];
            v_nz  = v_nz | (v_dig != 4'd0);
            if (r_ovf) begin
                w_new_disp[i] = 8'hBF;
            end else if (r_blank && (i != 0) && !v_nz) begin
                w_new_disp[i] = 8'hFF;
            end else begin
                w_new_disp[i] = {~r_dpc[i], f_glyph(v_dig)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
            r_val   <= '0;
            r_mode  <= 1'b0;
            r_blank <= 1'b0;
            r_dpc   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
            r_disp  <= '1;
        end else begin
            case (r_state)
                ST_HEX: begin
                    r_disp  <= w_new_disp;
                    r_state <= ST_IDLE;
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[c_BCD_W-2:0], r_val[DATA_W-1]};
                    r_ovf <= r_ovf | w_bcd_adj[c_BCD_W-1];
                    r_val <= r_val << 1;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(DATA_W - 1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_disp  <= w_new_disp;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: ;
            endcase
            // An accept in ST_HEX still commits the previous value first.
            if (load && !busy) begin
                r_val   <= data;
                r_mode  <= mode;
                r_blank <= blank_lz;
                r_dpc   <= dp;
                r_bcd   <= '0;
                r_ovf   <= 1'b0;
                r_cnt   <= '0;
                busy    <= mode;
                r_state <= mode ? ST_SHIFT : ST_HEX;
            end
        end
    end

    assign w_wrap    = (r_pre == c_PRE_W'(SCAN_DIV - 1));
    assign w_idx_nxt = !w_wrap ? r_idx :
                       (r_idx == c_IDX_W'(DIGITS - 1)) ? '0 : r_idx + c_IDX_W'(1);

    // Dis and Cs are both loaded from the next index so they switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
            dis   <= 8'hFF;
            cs    <= ~DIGITS'(1);
        end else begin
            r_pre <= w_wrap ? '0 : r_pre + c_PRE_W'(1);
            r_idx <= w_idx_nxt;
            cs    <= ~(DIGITS'(1) << w_idx_nxt);
            dis   <= r_disp[w_idx_nxt];
        end
    end

endmodule
`default_nettype wire
